input_conditioner: RTL and testbench
====================================

# input_conditioner

Conditions the raw DE10-Lite pushbutton and slide-switch pins before they reach the `codebreaker` system's button and switch PIO exports. Each input is synchronised and debounced. The block also produces one-cycle press pulses per button and a one-cycle any-switch-changed pulse. It sits between the board pins and the `codebreaker` instance in the top level, so software sees glitch-free levels.

## Interface
Parameters:
- `SYNC_STAGES`, 2 — flip-flop stages in each input synchroniser; minimum 2.
- `DB_CYCLES`, 500000 — consecutive stable cycles required to accept a new level (10 ms at 50 MHz); minimum 1.
- `REPEAT_DELAY`, 25000000 — cycles from the press pulse to the first auto-repeat pulse (used only with the repeat macro).
- `REPEAT_PERIOD`, 5000000 — cycles between later auto-repeat pulses (used only with the repeat macro).

Ports:
- `clk_clk`  in  1  system clock; the only clock.
- `reset_reset`  in  1  synchronous, active-high reset.
- `key_n_in`  in  4  raw pushbuttons, active-low.
- `sw_in`  in  10  raw slide switches.
- `button_level`  out  4  debounced buttons, active-low (same polarity as the board); drives the button PIO.
- `switch_level`  out  10  debounced switches; drives the switch PIO.
- `button_press`  out  4  one-cycle pulse per button on an accepted press (high→low).
- `switch_change`  out  1  one-cycle pulse when any `switch_level` bit changes.

## Operation
- Synchroniser: `SYNC_STAGES` flops per bit.
  - Reset value is 1 for keys and 0 for switches.
- Debouncer, per bit, with a counter of width `$clog2(DB_CYCLES+1)`:
  - If the synchronised value equals the current level, the counter clears to 0.
  - If they differ, the counter increments.
  - When the counter reaches `DB_CYCLES-1` while the values still differ, the level takes the synchronised value and the counter clears.
  - A bounce shorter than `DB_CYCLES` cycles never changes the level.
- Settle window: after reset, a counter runs for `SYNC_STAGES+DB_CYCLES` cycles.
  - Levels update normally during the window.
  - `button_press` and `switch_change` are forced to 0 during the window.
  - This stops a switch that is already on at power-up from producing a spurious change pulse.
- Per-button press FSM, states IDLE / HELD_DELAY / HELD_REPEAT:
  - IDLE → HELD_DELAY on a level fall; `button_press` pulses in the same cycle.
  - HELD_DELAY → HELD_REPEAT after `REPEAT_DELAY` cycles; pulse.
  - HELD_REPEAT pulses every `REPEAT_PERIOD` cycles.
  - A level rise in any state returns to IDLE with no pulse.
  - A release in the same cycle a repeat pulse falls due: the release wins and no pulse is issued.
- `switch_change` = OR of per-bit level changes. Several switches changing in one cycle give a single pulse.
- Reset mid-operation: all FSMs go to IDLE, all counters clear, and the settle window restarts.
- Buttons are independent. Simultaneous presses pulse their own `button_press` bits in the same cycle.

## Timing
- All outputs are registered.
- Reset values:
  - `button_level` = 4'hF
  - `switch_level` = 10'h000
  - `button_press` = 0
  - `switch_change` = 0
- Latency: a raw change first sampled at edge N, and held, appears on the level output at edge N+`SYNC_STAGES`+`DB_CYCLES`-1.
- `button_press` and `switch_change` assert in the same cycle as the level change that causes them.

## Configuration
- Macro: `INPUT_COND_REPEAT_EN`.
- Defined: auto-repeat behaves as described in Operation.
- Undefined:
  - The FSM reduces to IDLE/HELD: exactly one pulse per press, none while held.
  - `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.
  - The repeat counter is not synthesised.

## Structure
- Package `input_cond_pkg`, containing:
  - `NUM_KEYS`=4 and `NUM_SWITCHES`=10
  - the press FSM state enum
  - a width-helper function for counter sizing
- Sub-module `debounce_bit`: synchroniser, stable counter and level register. Outputs the level and a one-cycle change strobe.
  - Parameter `RESET_LEVEL` sets the level's reset value: 1 for keys, 0 for switches.
  - 14 instances.
- The top of `input_conditioner` holds the settle counter, the press FSMs and the `switch_change` OR.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `DB_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3, settle window = 6 cycles.
- Clean press: after the settle window, `key_n_in[0]` goes 1→0 at edge 20 and is held → `button_level[0]` falls and `button_press[0]` pulses for one cycle at edge 25.
- Bounce: `key_n_in[1]` toggles 0/1/0/1 with 2-cycle phases, then rests at 1 → `button_level[1]` stays 1 and no `button_press`.
- Power-up switch: `sw_in`=10'h201 held through reset release → `switch_level`=10'h201 at edge 5 after reset, `switch_change` stays 0.
- Simultaneous switches: `sw_in` 10'h000→10'h003 after settle → one `switch_change` pulse, `switch_level`=10'h003.
- Repeat, with the macro defined: hold `key_n_in[2]` low → press pulse at T, repeat pulses at T+10, T+13 and T+16; release at T+15 → no pulse at T+16.
  - Without the macro: hold → single pulse at T only.
- Mid-operation reset: assert `reset_reset` while a button is held in HELD_REPEAT → all outputs return to their reset values the next cycle, and no pulses occur for 6 cycles after release.

Source files
------------

// File: rtl/input_cond_pkg.sv
// Shared constants, press FSM state type and counter sizing helper for input_conditioner.
package input_cond_pkg;

    localparam int unsigned NUM_KEYS     = 4;
    localparam int unsigned NUM_SWITCHES = 10;

    typedef enum logic [1:0] {
        StIdle,
        StHeldDelay,
        StHeldRepeat
    } press_state_e;

    // Bits needed to hold values 0..max_count.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One-bit synchroniser plus stable-count debouncer. The update strobe is the combinational
// next-cycle level flip; change is its registered copy, aligned with the level output.
module debounce_bit
    import input_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 4,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic change,
    output logic update
);

    localparam int unsigned CW = cnt_width(DB_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, change_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        update = 1'b0;
        cnt_d  = cnt_q;
        if (sync_out == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
            update = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
            cnt_q    <= '0;
            level_q  <= RESET_LEVEL;
            change_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
            cnt_q    <= cnt_d;
            level_q  <= update ? sync_out : level_q;
            change_q <= update;
        end
    end

    assign level  = level_q;
    assign change = change_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces DE10-Lite keys and switches, generating press and switch-change pulses.
// Optional auto-repeat on held buttons is enabled by defining INPUT_COND_REPEAT_EN.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DB_CYCLES     = 500000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic [NUM_KEYS-1:0]     key_n_in,
    input  logic [NUM_SWITCHES-1:0] sw_in,
    output logic [NUM_KEYS-1:0]     button_level,
    output logic [NUM_SWITCHES-1:0] switch_level,
    output logic [NUM_KEYS-1:0]     button_press,
    output logic                    switch_change
);

    localparam int unsigned SETTLE = SYNC_STAGES + DB_CYCLES;
    localparam int unsigned SW     = cnt_width(SETTLE);

    logic [SW-1:0]           settle_q;
    logic                    settle_done;
    logic [NUM_KEYS-1:0]     key_upd, key_change_unused, key_fall, key_rise;
    logic [NUM_SWITCHES-1:0] sw_upd, sw_change_unused;
    logic [NUM_KEYS-1:0]     press_d, press_q;
    logic                    switch_change_q;
    press_state_e            state_q [NUM_KEYS];
    press_state_e            state_d [NUM_KEYS];

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        debounce_bit #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES),
            .RESET_LEVEL(1'b1)
        ) u_db (
            .clk   (clk_clk),
            .rst   (reset_reset),
            .din   (key_n_in[i]),
            .level (button_level[i]),
            .change(key_change_unused[i]),
            .update(key_upd[i])
        );
    end

    for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_sw
        debounce_bit #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES),
            .RESET_LEVEL(1'b0)
        ) u_db (
            .clk   (clk_clk),
            .rst   (reset_reset),
            .din   (sw_in[i]),
            .level (switch_level[i]),
            .change(sw_change_unused[i]),
            .update(sw_upd[i])
        );
    end

    // Pulses are suppressed until the power-up levels have had time to settle.
    assign settle_done = (settle_q == SW'(SETTLE));
    assign key_fall    = key_upd & button_level;
    assign key_rise    = key_upd & ~button_level;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            settle_q <= '0;
        end else if (!settle_done) begin
            settle_q <= settle_q + 1'b1;
        end
    end

`ifdef INPUT_COND_REPEAT_EN
    localparam int unsigned RW =
        cnt_width(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);

    logic [RW-1:0] rep_q [NUM_KEYS];
    logic [RW-1:0] rep_d [NUM_KEYS];
`else
    logic [63:0] repeat_unused;
    assign repeat_unused = {REPEAT_DELAY, REPEAT_PERIOD};
`endif

    // State register
    always_ff @(posedge clk_clk) begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (reset_reset) begin
                state_q[i] <= StIdle;
`ifdef INPUT_COND_REPEAT_EN
                rep_q[i]   <= '0;
`endif
            end else begin
                state_q[i] <= state_d[i];
`ifdef INPUT_COND_REPEAT_EN
                rep_q[i]   <= rep_d[i];
`endif
            end
        end
    end

    // Next-state logic; a release always wins over a repeat falling due.
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            state_d[i] = state_q[i];
`ifdef INPUT_COND_REPEAT_EN
            rep_d[i]   = rep_q[i];
`endif
            unique case (state_q[i])
                StIdle: begin
                    if (key_fall[i]) begin
                        state_d[i] = StHeldDelay;
`ifdef INPUT_COND_REPEAT_EN
                        rep_d[i]   = '0;
`endif
                    end
                end
                StHeldDelay: begin
                    if (key_rise[i]) begin
                        state_d[i] = StIdle;
`ifdef INPUT_COND_REPEAT_EN
                    end else if (rep_q[i] == RW'(REPEAT_DELAY - 1)) begin
                        state_d[i] = StHeldRepeat;
                        rep_d[i]   = '0;
                    end else begin
                        rep_d[i] = rep_q[i] + 1'b1;
`endif
                    end
                end
                StHeldRepeat: begin
                    if (key_rise[i]) begin
                        state_d[i] = StIdle;
`ifdef INPUT_COND_REPEAT_EN
                    end else if (rep_q[i] == RW'(REPEAT_PERIOD - 1)) begin
                        rep_d[i] = '0;
                    end else begin
                        rep_d[i] = rep_q[i] + 1'b1;
`endif
                    end
                end
                default: state_d[i] = StIdle;
            endcase
        end
    end

    // Output logic
    always_comb begin
        press_d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            unique case (state_q[i])
                StIdle:       press_d[i] = key_fall[i];
`ifdef INPUT_COND_REPEAT_EN
                StHeldDelay:  press_d[i] = !key_rise[i] && (rep_q[i] == RW'(REPEAT_DELAY - 1));
                StHeldRepeat: press_d[i] = !key_rise[i] && (rep_q[i] == RW'(REPEAT_PERIOD - 1));
`else
                StHeldDelay:  press_d[i] = 1'b0;
                StHeldRepeat: press_d[i] = 1'b0;
`endif
                default:      press_d[i] = 1'b0;
            endcase
        end
        press_d = settle_done ? press_d : '0;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            press_q         <= '0;
            switch_change_q <= 1'b0;
        end else begin
            press_q         <= press_d;
            switch_change_q <= settle_done && (|sw_upd);
        end
    end

    assign button_press  = press_q;
    assign switch_change = switch_change_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner with short debounce and repeat timing.
// Edge 0 is the first rising edge after reset is released.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       reset_reset;
    logic [3:0] key_n_in;
    logic [9:0] sw_in;
    logic [3:0] button_level;
    logic [9:0] switch_level;
    logic [3:0] button_press;
    logic       switch_change;

    int errors = 0;
    int checks = 0;
    int edge_no = 0;

    input_conditioner #(
        .SYNC_STAGES  (2),
        .DB_CYCLES    (4),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk_clk      (clk),
        .reset_reset  (reset_reset),
        .key_n_in     (key_n_in),
        .sw_in        (sw_in),
        .button_level (button_level),
        .switch_level (switch_level),
        .button_press (button_press),
        .switch_change(switch_change)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_no++;
    endtask

    task automatic step_to(input int target);
        while (edge_no < target) step();
    endtask

    logic [31:0] pv;
    logic [3:0]  other;
    int          pulses;
    int          pulse_at;

    initial begin
        reset_reset = 1'b1;
        key_n_in    = 4'hF;
        sw_in       = 10'h201;
        step();
        step();
        step();
        check("rst_button_level", 32'(button_level), 32'hF);
        check("rst_switch_level", 32'(switch_level), 32'h000);
        check("rst_button_press", 32'(button_press), 32'h0);
        check("rst_switch_change", 32'(switch_change), 32'h0);

        // Power-up switch: 10'h201 sampled from edge 0, level at edge 5, no change pulse.
        reset_reset = 1'b0;
        edge_no     = -1;
        for (int e = 0; e < 8; e++) begin
            step();
            check("pwrup_no_change", 32'(switch_change), 32'h0);
            if (e == 4) check("pwrup_level_e4", 32'(switch_level), 32'h000);
            if (e == 5) check("pwrup_level_e5", 32'(switch_level), 32'h201);
        end

        // Clean press: raw fall sampled at edge 20, level and pulse at edge 25.
        step_to(19);
        key_n_in[0] = 1'b0;
        step_to(24);
        check("press_e24_level", 32'(button_level), 32'hF);
        check("press_e24_pulse", 32'(button_press), 32'h0);
        step();
        check("press_e25_level", 32'(button_level), 32'hE);
        check("press_e25_pulse", 32'(button_press), 32'h1);
        step();
        check("press_e26_pulse", 32'(button_press), 32'h0);
        key_n_in[0] = 1'b1;
        step_to(31);
        check("release_e31_level", 32'(button_level), 32'hE);
        step();
        check("release_e32_level", 32'(button_level), 32'hF);
        check("release_e32_pulse", 32'(button_press), 32'h0);

        // Bounce with 2-cycle phases never reaches the 4-cycle threshold.
        for (int e = 0; e < 14; e++) begin
            key_n_in[1] = (e < 6) ? e[1] : 1'b1;
            step();
            check("bounce_level", 32'(button_level), 32'hF);
            check("bounce_pulse", 32'(button_press), 32'h0);
        end

        // Simultaneous switches: 000 -> 003 gives one pulse, 5 edges after first sample.
        sw_in = 10'h000;
        for (int e = 0; e < 8; e++) step();
        check("sw_clear_level", 32'(switch_level), 32'h000);
        sw_in    = 10'h003;
        pulses   = 0;
        pulse_at = -1;
        for (int o = 0; o < 8; o++) begin
            step();
            if (switch_change) begin
                pulses++;
                pulse_at = o;
            end
        end
        check("sw_pulse_count", 32'(pulses), 32'd1);
        check("sw_pulse_edge", 32'(pulse_at), 32'd5);
        check("sw_level", 32'(switch_level), 32'h003);

        // Repeat on key 2: T = offset 5; level rises at offset 21 (T+16) when a repeat falls due.
        key_n_in[2] = 1'b0;
        pv          = '0;
        other       = '0;
        for (int o = 0; o < 25; o++) begin
            step();
            pv[o] = button_press[2];
            other = other | (button_press & 4'b1011);
            if (o == 15) key_n_in[2] = 1'b1;
            if (o == 20) check("rep_level_o20", 32'(button_level[2]), 32'h0);
            if (o == 21) check("rep_level_o21", 32'(button_level[2]), 32'h1);
        end
`ifdef INPUT_COND_REPEAT_EN
        check("rep_pulse_pattern", pv, (32'd1 << 5) | (32'd1 << 15) | (32'd1 << 18));
`else
        check("rep_pulse_pattern", pv, 32'd1 << 5);
`endif
        check("rep_other_bits", 32'(other), 32'h0);

        // Simultaneous presses on keys 0 and 3, held long enough to reach repeat state.
        key_n_in = 4'b0110;
        for (int o = 0; o < 20; o++) begin
            step();
            if (o == 5) check("dual_press", 32'(button_press), 32'h9);
        end

        // Mid-operation reset while held.
        reset_reset = 1'b1;
        step();
        check("midrst_button_level", 32'(button_level), 32'hF);
        check("midrst_switch_level", 32'(switch_level), 32'h000);
        check("midrst_button_press", 32'(button_press), 32'h0);
        check("midrst_switch_change", 32'(switch_change), 32'h0);
        step();
        reset_reset = 1'b0;
        edge_no     = -1;
        for (int e = 0; e < 6; e++) begin
            step();
            check("settle_no_press", 32'(button_press), 32'h0);
            check("settle_no_change", 32'(switch_change), 32'h0);
        end
        check("settle_button_level", 32'(button_level), 32'h6);
        check("settle_switch_level", 32'(switch_level), 32'h003);
        for (int e = 0; e < 4; e++) begin
            step();
            check("post_settle_quiet", 32'({button_press, switch_change}), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
